// File: rtl/rs_ff_pkg.sv
// Shared types and limits for the rs_ff flip-flop bank.
package rs_ff_pkg;

  typedef enum logic [1:0] {
    RS_HOLD       = 2'd0,
    RS_SET_WINS   = 2'd1,
    RS_RESET_WINS = 2'd2,
    RS_TOGGLE     = 2'd3
  } rs_policy_e;

  localparam int MAX_SYNC_STAGES = 3;

endpackage

// File: rtl/rs_ff_sync.sv
// WIDTH-bit, STAGES-deep reset-to-0 synchronizer; STAGES=0 is a pass-through.
module rs_ff_sync
  import rs_ff_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
    $error("rs_ff_sync: STAGES exceeds MAX_SYNC_STAGES");
  end

  if (STAGES == 0) begin : g_bypass
    assign q_o = d_i;
  end else begin : g_sync
    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[STAGES-1];
  end

endmodule

// File: rtl/rs_ff.sv
// Bank of independent clocked set/reset flags with selectable S=R=1 resolution
// and an optional input synchronizer.
module rs_ff
  import rs_ff_pkg::*;
#(
  parameter int         WIDTH           = 1,
  parameter rs_policy_e CONFLICT_POLICY = RS_RESET_WINS,
  parameter int         SYNC_STAGES     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] R,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_B,
  output logic [WIDTH-1:0] conflict
);

  if (SYNC_STAGES < 0 || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
    $error("rs_ff: SYNC_STAGES out of range 0..MAX_SYNC_STAGES");
  end

  if (CONFLICT_POLICY != RS_HOLD && CONFLICT_POLICY != RS_SET_WINS &&
      CONFLICT_POLICY != RS_RESET_WINS && CONFLICT_POLICY != RS_TOGGLE) begin : g_bad_policy
    $error("rs_ff: unknown CONFLICT_POLICY");
  end

  logic [WIDTH-1:0] s_sync;
  logic [WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] conflict_q;

  rs_ff_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync_s (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (S),
    .q_o   (s_sync)
  );

  rs_ff_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync_r (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (R),
    .q_o   (r_sync)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    always_comb begin
      q_d[i] = q_q[i];
      unique case ({s_sync[i], r_sync[i]})
        2'b10:   q_d[i] = 1'b1;
        2'b01:   q_d[i] = 1'b0;
        2'b11: begin
          case (CONFLICT_POLICY)
            RS_SET_WINS:   q_d[i] = 1'b1;
            RS_RESET_WINS: q_d[i] = 1'b0;
            RS_TOGGLE:     q_d[i] = ~q_q[i];
            default:       q_d[i] = q_q[i];
          endcase
        end
        default: q_d[i] = q_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q        <= '0;
      conflict_q <= '0;
    end else begin
      q_q        <= q_d;
      conflict_q <= s_sync & r_sync;
    end
  end

  // Q_B is derived, not registered, so it can never disagree with Q.
  assign Q        = q_q;
  assign Q_B      = ~q_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_rs_ff.sv
// Directed self-checking bench for rs_ff: default config, policy sweep, synchronized 4-bit config.
module tb_rs_ff;
  import rs_ff_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s1 = 1'b0, r1 = 1'b0;
  logic [3:0] s4 = '0, r4 = '0;

  logic q_rw, qb_rw, c_rw;
  logic q_h, qb_h, c_h;
  logic q_sw, qb_sw, c_sw;
  logic q_t, qb_t, c_t;
  logic [3:0] q4, qb4, c4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rs_ff dut_rw (.clk(clk), .rst_n(rst_n), .R(r1), .S(s1), .Q(q_rw), .Q_B(qb_rw), .conflict(c_rw));
  rs_ff #(.CONFLICT_POLICY(RS_HOLD)) dut_h
    (.clk(clk), .rst_n(rst_n), .R(r1), .S(s1), .Q(q_h), .Q_B(qb_h), .conflict(c_h));
  rs_ff #(.CONFLICT_POLICY(RS_SET_WINS)) dut_sw
    (.clk(clk), .rst_n(rst_n), .R(r1), .S(s1), .Q(q_sw), .Q_B(qb_sw), .conflict(c_sw));
  rs_ff #(.CONFLICT_POLICY(RS_TOGGLE)) dut_t
    (.clk(clk), .rst_n(rst_n), .R(r1), .S(s1), .Q(q_t), .Q_B(qb_t), .conflict(c_t));
  rs_ff #(.WIDTH(4), .SYNC_STAGES(2)) dut_s4
    (.clk(clk), .rst_n(rst_n), .R(r4), .S(s4), .Q(q4), .Q_B(qb4), .conflict(c4));

  typedef struct {
    logic s;
    logic r;
    logic exp_q;
    logic exp_c;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edge_sample(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_rw(input string name, input logic eq, input logic ec);
    check({name, ".Q"},        {3'b0, q_rw},  {3'b0, eq});
    check({name, ".Q_B"},      {3'b0, qb_rw}, {3'b0, ~eq});
    check({name, ".conflict"}, {3'b0, c_rw},  {3'b0, ec});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{s:1'b1, r:1'b0, exp_q:1'b1, exp_c:1'b0};
    vecs[1] = '{s:1'b0, r:1'b0, exp_q:1'b1, exp_c:1'b0};
    vecs[2] = '{s:1'b0, r:1'b1, exp_q:1'b0, exp_c:1'b0};
    vecs[3] = '{s:1'b0, r:1'b0, exp_q:1'b0, exp_c:1'b0};
    vecs[4] = '{s:1'b1, r:1'b1, exp_q:1'b0, exp_c:1'b1};
    vecs[5] = '{s:1'b1, r:1'b0, exp_q:1'b1, exp_c:1'b0};
    vecs[6] = '{s:1'b1, r:1'b1, exp_q:1'b0, exp_c:1'b1};
    vecs[7] = '{s:1'b0, r:1'b0, exp_q:1'b0, exp_c:1'b0};

    // Get a known state, set Q=1, then assert reset with S held, between edges.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    s1 = 1'b1;
    edge_sample(2);
    check_rw("preset", 1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_rw("async_reset", 1'b0, 1'b0);
    edge_sample(1);
    check_rw("reset_held_with_S", 1'b0, 1'b0);
    @(negedge clk);
    s1 = 1'b0;
    rst_n = 1'b1;
    edge_sample(10);
    check_rw("release_hold", 1'b0, 1'b0);

    // Table: check one edge after each step, then again after holding.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s1 = vecs[i].s;
      r1 = vecs[i].r;
      edge_sample(1);
      check_rw($sformatf("vec%0d_edge1", i), vecs[i].exp_q, vecs[i].exp_c);
      edge_sample(9);
      check_rw($sformatf("vec%0d_held", i), vecs[i].exp_q, vecs[i].exp_c);
    end

    // Policy sweep: all instances to Q=1, then S=R=1 for three edges.
    @(negedge clk);
    s1 = 1'b1; r1 = 1'b0;
    edge_sample(1);
    check("sweep_pre_hold", {3'b0, q_h},  4'b0001);
    check("sweep_pre_set",  {3'b0, q_sw}, 4'b0001);
    check("sweep_pre_rw",   {3'b0, q_rw}, 4'b0001);
    check("sweep_pre_tog",  {3'b0, q_t},  4'b0001);
    @(negedge clk);
    r1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      edge_sample(1);
      check($sformatf("hold_e%0d", k), {3'b0, q_h},  4'b0001);
      check($sformatf("set_e%0d", k),  {3'b0, q_sw}, 4'b0001);
      check($sformatf("rw_e%0d", k),   {3'b0, q_rw}, 4'b0000);
      check($sformatf("tog_e%0d", k),  {3'b0, q_t},  (k == 1) ? 4'b0001 : 4'b0000);
      check($sformatf("tog_qb_e%0d", k), {3'b0, qb_t}, (k == 1) ? 4'b0000 : 4'b0001);
      check($sformatf("tog_conf_e%0d", k), {3'b0, c_t}, 4'b0001);
    end
    @(negedge clk);
    r1 = 1'b0;
    edge_sample(1);
    check_rw("conflict_release", 1'b1, 1'b0);
    @(negedge clk);
    s1 = 1'b0;

    // Synchronized 4-bit: 3-edge latency.
    @(negedge clk);
    s4 = 4'b0101;
    edge_sample(2);
    check("sync_edge2_Q", q4, 4'b0000);
    edge_sample(1);
    check("sync_edge3_Q",   q4,  4'b0101);
    check("sync_edge3_Q_B", qb4, 4'b1010);
    check("sync_conflict",  c4,  4'b0000);
    @(negedge clk);
    s4 = 4'b0000;
    edge_sample(3);
    check("sync_hold_Q", q4, 4'b0101);

    // Reset mid-pipeline: new set request must not emerge after release.
    @(negedge clk);
    s4 = 4'b1010;
    edge_sample(1);
    check("pipe_not_yet", q4, 4'b0101);
    #2;
    rst_n = 1'b0;
    #1;
    check("pipe_reset_Q",   q4,  4'b0000);
    check("pipe_reset_Q_B", qb4, 4'b1111);
    s4 = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      edge_sample(1);
      check($sformatf("pipe_no_late_e%0d", k), q4, 4'b0000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
